// File: rtl/chime_alarm_ctrl.sv
// Hourly chime plus HH:MM wake alarm with ring timeout, snooze and stop.
// Everything runs on the 1 kHz system clock; both tones are derived from a
// free-running 2-bit counter and a single registered buzzer output is driven.
//
// Ports:
//   clk_1kHz, rst_n      : 1 kHz clock, asynchronous active-low reset
//   sec_tick             : one-cycle pulse, time inputs already show the new second
//   h/m/s_cntH/L         : current time, BCD
//   alarm_hH..alarm_mL   : alarm time, BCD
//   alarm_en, chime_en   : level enables
//   snooze, stop         : one-cycle user pulses
//   alarm                : registered buzzer drive
//   ringing, snoozing    : state indicators
//   snooze_cnt           : snoozes used in the current alarm event
module chime_alarm_ctrl #(
  parameter int unsigned N_BEEPS    = 4,
  parameter int unsigned CHIME_MS   = 500,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk_1kHz,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [3:0] h_cntH,
  input  logic [3:0] h_cntL,
  input  logic [3:0] m_cntH,
  input  logic [3:0] m_cntL,
  input  logic [3:0] s_cntH,
  input  logic [3:0] s_cntL,
  input  logic [3:0] alarm_hH,
  input  logic [3:0] alarm_hL,
  input  logic [3:0] alarm_mH,
  input  logic [3:0] alarm_mL,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_cnt
);

  localparam int unsigned SnzSecs = SNOOZE_MIN * 60;
  localparam int unsigned RingW   = $clog2(RING_SECS + 1);
  localparam int unsigned SnzW    = $clog2(SnzSecs + 1);
  localparam int unsigned ChimeW  = $clog2(CHIME_MS + 1);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e              state_q, state_d;
  logic [1:0]          tone_cnt_q;
  logic [9:0]          ms_cnt_q, ms_cnt_d;
  logic [ChimeW-1:0]   chime_cnt_q, chime_cnt_d;
  logic                chime_hi_q, chime_hi_d;
  logic [RingW-1:0]    ring_sec_q, ring_sec_d;
  logic [SnzW-1:0]     snz_sec_q, snz_sec_d;
  logic [2:0]          snooze_cnt_q, snooze_cnt_d;
  logic                alarm_q, alarm_d;

  logic chime_hit, chime_last, chime_on, chime_tone, tone_sel, time_match;

  // BCD second on which beep k starts: 59 - 2*N_BEEPS + 2*k.
  function automatic logic [7:0] beep_sec_bcd(input int unsigned k);
    int unsigned s;
    s = 59 - 2 * N_BEEPS + 2 * k;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  // Literal BCD compare: malformed digits simply never match.
  always_comb begin
    chime_hit  = 1'b0;
    chime_last = 1'b0;
    if (sec_tick && chime_en && ({m_cntH, m_cntL} == 8'h59)) begin
      for (int unsigned k = 0; k < N_BEEPS; k++) begin
        if ({s_cntH, s_cntL} == beep_sec_bcd(k)) begin
          chime_hit  = 1'b1;
          chime_last = (k == N_BEEPS - 1);
        end
      end
    end
  end

  assign time_match = alarm_en &&
                      ({h_cntH, h_cntL, m_cntH, m_cntL} ==
                       {alarm_hH, alarm_hL, alarm_mH, alarm_mL}) &&
                      ({s_cntH, s_cntL} == 8'h00);

  // Beep counter: the start cycle counts as the first of CHIME_MS cycles.
  always_comb begin
    chime_cnt_d = chime_cnt_q;
    chime_hi_d  = chime_hi_q;
    if (chime_hit) begin
      chime_cnt_d = ChimeW'(CHIME_MS - 1);
      chime_hi_d  = chime_last;
    end else if (chime_cnt_q != '0) begin
      chime_cnt_d = chime_cnt_q - 1'b1;
    end
  end

  assign ms_cnt_d = sec_tick ? 10'd0 : ((ms_cnt_q == 10'd999) ? ms_cnt_q : ms_cnt_q + 10'd1);

  always_comb begin
    state_d      = state_q;
    ring_sec_d   = ring_sec_q;
    snz_sec_d    = snz_sec_q;
    snooze_cnt_d = snooze_cnt_q;
    unique case (state_q)
      StIdle: begin
        snooze_cnt_d = '0;
        if (sec_tick && time_match) begin
          state_d    = StRing;
          ring_sec_d = RingW'(RING_SECS);
        end
      end
      StRing: begin
        if (!alarm_en || stop) begin
          state_d      = StIdle;
          snooze_cnt_d = '0;
        end else if (snooze && (snooze_cnt_q < 3'(MAX_SNOOZE))) begin
          state_d      = StSnooze;
          snooze_cnt_d = snooze_cnt_q + 3'd1;
          snz_sec_d    = SnzW'(SnzSecs);
        end else if (sec_tick) begin
          if (ring_sec_q <= RingW'(1)) begin
            state_d      = StIdle;
            ring_sec_d   = '0;
            snooze_cnt_d = '0;
          end else begin
            ring_sec_d = ring_sec_q - 1'b1;
          end
        end
      end
      StSnooze: begin
        if (!alarm_en || stop) begin
          state_d      = StIdle;
          snooze_cnt_d = '0;
        end else if (sec_tick) begin
          if (snz_sec_q <= SnzW'(1)) begin
            state_d    = StRing;
            snz_sec_d  = '0;
            ring_sec_d = RingW'(RING_SECS);
          end else begin
            snz_sec_d = snz_sec_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ring pattern has priority; the chime is silenced while ringing.
  assign tone_sel   = chime_hit ? chime_last : chime_hi_q;
  assign chime_tone = tone_sel ? tone_cnt_q[0] : tone_cnt_q[1];
  assign chime_on   = chime_en && (chime_hit || (chime_cnt_q != '0));

  always_comb begin
    alarm_d = 1'b0;
    if (state_q == StRing) begin
      alarm_d = (ms_cnt_q < 10'd500) && tone_cnt_q[0];
    end else begin
      alarm_d = chime_on && chime_tone;
    end
  end

  always_ff @(posedge clk_1kHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tone_cnt_q   <= '0;
      ms_cnt_q     <= '0;
      chime_cnt_q  <= '0;
      chime_hi_q   <= 1'b0;
      ring_sec_q   <= '0;
      snz_sec_q    <= '0;
      snooze_cnt_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tone_cnt_q   <= tone_cnt_q + 2'd1;
      ms_cnt_q     <= ms_cnt_d;
      chime_cnt_q  <= chime_cnt_d;
      chime_hi_q   <= chime_hi_d;
      ring_sec_q   <= ring_sec_d;
      snz_sec_q    <= snz_sec_d;
      snooze_cnt_q <= snooze_cnt_d;
      alarm_q      <= alarm_d;
    end
  end

  assign alarm      = alarm_q;
  assign ringing    = (state_q == StRing);
  assign snoozing   = (state_q == StSnooze);
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
module tb_chime_alarm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sec_tick, alarm_en, chime_en, snooze, stop;
  logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
  logic [3:0] alarm_hH, alarm_hL, alarm_mH, alarm_mL;

  logic       alarm_m, ringing_m, snoozing_m;
  logic [2:0] scnt_m;
  logic       alarm_a, ringing_a, snoozing_a;
  logic [2:0] scnt_a;
  logic       alarm_b, ringing_b, snoozing_b;
  logic [2:0] scnt_b;

  // Main unit: default chime, one-minute snooze.
  chime_alarm_ctrl #(
    .N_BEEPS(4), .CHIME_MS(500), .RING_SECS(60), .SNOOZE_MIN(1), .MAX_SNOOZE(3)
  ) dut (
    .clk_1kHz(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .h_cntH(h_cntH), .h_cntL(h_cntL), .m_cntH(m_cntH), .m_cntL(m_cntL),
    .s_cntH(s_cntH), .s_cntL(s_cntL),
    .alarm_hH(alarm_hH), .alarm_hL(alarm_hL), .alarm_mH(alarm_mH), .alarm_mL(alarm_mL),
    .alarm_en(alarm_en), .chime_en(chime_en), .snooze(snooze), .stop(stop),
    .alarm(alarm_m), .ringing(ringing_m), .snoozing(snoozing_m), .snooze_cnt(scnt_m)
  );

  chime_alarm_ctrl #(.N_BEEPS(1), .CHIME_MS(8)) dut_n1 (
    .clk_1kHz(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .h_cntH(h_cntH), .h_cntL(h_cntL), .m_cntH(m_cntH), .m_cntL(m_cntL),
    .s_cntH(s_cntH), .s_cntL(s_cntL),
    .alarm_hH(alarm_hH), .alarm_hL(alarm_hL), .alarm_mH(alarm_mH), .alarm_mL(alarm_mL),
    .alarm_en(alarm_en), .chime_en(chime_en), .snooze(snooze), .stop(stop),
    .alarm(alarm_a), .ringing(ringing_a), .snoozing(snoozing_a), .snooze_cnt(scnt_a)
  );

  chime_alarm_ctrl #(.N_BEEPS(5), .CHIME_MS(8)) dut_n5 (
    .clk_1kHz(clk), .rst_n(rst_n), .sec_tick(sec_tick),
    .h_cntH(h_cntH), .h_cntL(h_cntL), .m_cntH(m_cntH), .m_cntL(m_cntL),
    .s_cntH(s_cntH), .s_cntL(s_cntL),
    .alarm_hH(alarm_hH), .alarm_hL(alarm_hL), .alarm_mH(alarm_mH), .alarm_mL(alarm_mL),
    .alarm_en(alarm_en), .chime_en(chime_en), .snooze(snooze), .stop(stop),
    .alarm(alarm_b), .ringing(ringing_b), .snoozing(snoozing_b), .snooze_cnt(scnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic rec_m [1000];
  logic rec_a [1000];
  logic rec_b [1000];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic set_time(input int h, input int m, input int s);
    {h_cntH, h_cntL} = bcd(h);
    {m_cntH, m_cntL} = bcd(m);
    {s_cntH, s_cntL} = bcd(s);
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    step(1);
    sec_tick = 1'b0;
  endtask

  task automatic fast_tick();
    pulse_tick();
    step(4);
  endtask

  task automatic pulse_in(input logic do_snooze, input logic do_stop);
    snooze = do_snooze;
    stop   = do_stop;
    step(1);
    snooze = 1'b0;
    stop   = 1'b0;
  endtask

  // Samples 0..998 after a tick; sample i is taken just after the i-th edge.
  task automatic record();
    for (int i = 0; i < 999; i++) begin
      rec_m[i] = alarm_m;
      rec_a[i] = alarm_a;
      rec_b[i] = alarm_b;
      step(1);
    end
  endtask

  function automatic logic get(input int w, input int i);
    if (w == 0) return rec_m[i];
    if (w == 1) return rec_a[i];
    return rec_b[i];
  endfunction

  function automatic int ones(input int w, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(get(w, i));
    return c;
  endfunction

  function automatic int trans(input int w, input int lo, input int hi);
    int c = 0;
    for (int i = lo + 1; i <= hi; i++) if (get(w, i) != get(w, i - 1)) c++;
    return c;
  endfunction

  // kind: 0 silent, 1 low-tone beep, 2 high-tone beep
  task automatic check_chime(input string tag, input int w, input int kind);
    if (w == 0) begin
      check({tag, " on"},    ones(w, 0, 499),   (kind != 0) ? 250 : 0);
      check({tag, " tone"},  trans(w, 0, 400),  (kind == 2) ? 400 : (kind == 1) ? 200 : 0);
      check({tag, " off"},   ones(w, 500, 998), 0);
    end else begin
      check({tag, " on"},    ones(w, 0, 7),     (kind != 0) ? 4 : 0);
      check({tag, " tone"},  trans(w, 0, 4),    (kind == 2) ? 4 : (kind == 1) ? 2 : 0);
      check({tag, " off"},   ones(w, 8, 998),   0);
    end
  endtask

  task automatic check_ring_second(input string tag);
    check({tag, " s0"},   int'(rec_m[0]), 0);
    check({tag, " on"},   ones(0, 1, 500), 250);
    check({tag, " tone"}, trans(0, 1, 500), 499);
    check({tag, " off"},  ones(0, 501, 998), 0);
  endtask

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0; chime_en = 1'b0;
    snooze = 1'b0; stop = 1'b0;
    set_time(0, 0, 0);
    {alarm_hH, alarm_hL, alarm_mH, alarm_mL} = 16'h0730;
    step(3);
    check("rst alarm", alarm_m, 0);
    check("rst ringing", ringing_m, 0);
    check("rst snoozing", snoozing_m, 0);
    check("rst snooze_cnt", scnt_m, 0);
    check("rst alarm n1", alarm_a, 0);
    check("rst alarm n5", alarm_b, 0);
    rst_n = 1'b1;
    step(2);

    // Chime over the end of the hour, all three beep counts in parallel.
    chime_en = 1'b1;
    for (int ss = 47; ss <= 59; ss++) begin
      int km, k1, k5;
      km = (ss == 57) ? 2 : ((ss >= 51 && ss <= 55 && (ss % 2) == 1) ? 1 : 0);
      k1 = (ss == 57) ? 2 : 0;
      k5 = (ss == 57) ? 2 : ((ss >= 49 && ss <= 55 && (ss % 2) == 1) ? 1 : 0);
      set_time(0, 59, ss);
      pulse_tick();
      record();
      check_chime($sformatf("chime n4 s%0d", ss), 0, km);
      check_chime($sformatf("chime n1 s%0d", ss), 1, k1);
      check_chime($sformatf("chime n5 s%0d", ss), 2, k5);
    end
    set_time(1, 0, 51);
    pulse_tick();
    record();
    check_chime("min00 s51 n4", 0, 0);
    check_chime("min00 s51 n5", 2, 0);
    set_time(1, 0, 57);
    pulse_tick();
    record();
    check_chime("min00 s57 n4", 0, 0);
    check_chime("min00 s57 n1", 1, 0);
    chime_en = 1'b0;
    set_time(0, 59, 57);
    pulse_tick();
    record();
    check_chime("chime_en0 n4", 0, 0);
    check_chime("chime_en0 n1", 1, 0);

    // Alarm with timeout.
    alarm_en = 1'b1;
    set_time(7, 29, 59);
    pulse_tick();
    check("pre-match ringing", ringing_m, 0);
    set_time(7, 30, 0);
    pulse_tick();
    check("ring start", ringing_m, 1);
    check("ring start cnt", scnt_m, 0);
    record();
    check_ring_second("ring sec1");
    set_time(7, 30, 1);
    repeat (59) fast_tick();
    check("ring after 59 ticks", ringing_m, 1);
    fast_tick();
    check("ring timeout", ringing_m, 0);
    step(2);
    check("alarm after timeout", alarm_m, 0);

    // Snooze up to the limit.
    set_time(7, 30, 0);
    pulse_tick();
    check("ring again", ringing_m, 1);
    set_time(7, 30, 1);
    for (int r = 1; r <= 3; r++) begin
      pulse_in(1'b1, 1'b0);
      check($sformatf("snoozing r%0d", r), snoozing_m, 1);
      check($sformatf("snooze ringing r%0d", r), ringing_m, 0);
      check($sformatf("snooze_cnt r%0d", r), scnt_m, r);
      step(2);
      check($sformatf("snooze quiet r%0d", r), alarm_m, 0);
      repeat (59) fast_tick();
      check($sformatf("still snoozing r%0d", r), snoozing_m, 1);
      fast_tick();
      check($sformatf("re-ring r%0d", r), ringing_m, 1);
      check($sformatf("re-ring cnt r%0d", r), scnt_m, r);
    end
    pulse_in(1'b1, 1'b0);
    check("4th snooze ringing", ringing_m, 1);
    check("4th snooze snoozing", snoozing_m, 0);
    check("4th snooze cnt", scnt_m, 3);
    pulse_in(1'b0, 1'b1);
    check("stop ringing", ringing_m, 0);
    check("stop cnt", scnt_m, 0);

    // Ring during the chime window, then stop and snooze together.
    {alarm_hH, alarm_hL, alarm_mH, alarm_mL} = 16'h1359;
    chime_en = 1'b1;
    set_time(13, 59, 0);
    pulse_tick();
    check("ring 13:59", ringing_m, 1);
    record();
    set_time(13, 59, 51);
    pulse_tick();
    record();
    check_ring_second("ring over chime");
    pulse_in(1'b1, 1'b1);
    check("prio ringing", ringing_m, 0);
    check("prio snoozing", snoozing_m, 0);
    check("prio cnt", scnt_m, 0);
    chime_en = 1'b0;

    // Asynchronous reset while ringing after one snooze.
    set_time(13, 59, 0);
    pulse_tick();
    set_time(13, 59, 1);
    pulse_in(1'b1, 1'b0);
    repeat (60) fast_tick();
    repeat (4) if (alarm_m !== 1'b1) step(1);
    check("pre-reset ringing", ringing_m, 1);
    check("pre-reset cnt", scnt_m, 1);
    check("pre-reset alarm", alarm_m, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst alarm", alarm_m, 0);
    check("async rst ringing", ringing_m, 0);
    check("async rst cnt", scnt_m, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);

    // alarm_en dropped while snoozing.
    set_time(13, 59, 0);
    pulse_tick();
    check("ring for en-drop", ringing_m, 1);
    pulse_in(1'b1, 1'b0);
    check("snooze for en-drop", snoozing_m, 1);
    alarm_en = 1'b0;
    step(1);
    check("en-drop snoozing", snoozing_m, 0);
    check("en-drop ringing", ringing_m, 0);
    check("en-drop cnt", scnt_m, 0);
    alarm_en = 1'b1;
    set_time(13, 59, 1);
    repeat (70) fast_tick();
    check("no later ring", ringing_m, 0);
    check("no later snooze", snoozing_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
